// File: rtl/uart_pkg.sv
// Shared UART definitions for the uart_tx / uart_rx pair.
//   uart_state_t : one-hot frame state encoding (IDLE/START/DATA/STOP)
//   DATA_BITS    : payload bits per frame
//   baud_width() : clk cycles per line bit for a given clock and baud rate
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } uart_state_t;

    function automatic int baud_width(input int clock_speed, input int baud_rate);
        return clock_speed / baud_rate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
//   clk      : destination clock
//   rst_n    : asynchronous active-low reset, loads RESET_VAL into both flops
//   d        : asynchronous input
//   q        : synchronized output, lags d by two clk edges
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: clocked state uses non-blocking assignments so both flops sample
    // their inputs from before the edge; blocking here would collapse the
    // chain into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit (low), 8 payload bits LSB first carried inverted
// on the line, 1 stop bit (high). Every bit is sampled at its midpoint.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   rx        : serial line, asynchronous to clk, idles high
//   data      : last correctly framed byte (payload re-inverted)
//   rx_valid  : one-cycle strobe, data updated this cycle
//   frame_err : one-cycle strobe, stop bit sampled low, byte discarded
//   busy      : high whenever a frame is in progress
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_RATE   = 115_200,
    parameter int CLOCK_SPEED = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int BAUD_WIDTH = baud_width(CLOCK_SPEED, BAUD_RATE);
    localparam int HALF_WIDTH = BAUD_WIDTH / 2;
    localparam int CNT_W      = $clog2(BAUD_WIDTH);
    localparam int IDX_W      = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_WIDTH - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    uart_state_t          state;
    logic [CNT_W-1:0]     counter;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 rx_s;

    // Line idles high, so the synchronizer resets to 1 to avoid a false
    // start edge right after reset release.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            counter   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    counter <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end

                // Wait half a bit, then confirm the line is still low so a
                // short glitch is not taken for a start bit.
                START: begin
                    if (counter == HALF_LAST) begin
                        counter <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end

                // Counter is now aligned to mid-bit; a full bit period later
                // lands in the middle of the next bit. Right-shifting into the
                // MSB leaves the first (LSB) bit at shift[0] after 8 samples.
                DATA: begin
                    if (counter == BAUD_LAST) begin
                        counter <= '0;
                        shift   <= {~rx_s, shift[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + IDX_W'(1);
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end

                // Leave at mid-stop so a start bit directly following the
                // stop bit is still caught.
                STOP: begin
                    if (counter == BAUD_LAST) begin
                        counter <= '0;
                        state   <= IDLE;
                        if (rx_s) begin
                            data     <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end

                // Any non-one-hot encoding recovers to IDLE.
                default: begin
                    state   <= IDLE;
                    counter <= '0;
                    bit_idx <= '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives line frames directly, keeps a
// queue of expected bytes and compares each rx_valid strobe against it.
module tb_uart_rx;

    localparam int BW = 434;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    int cyc = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int start_cyc = 0;
    int last_valid_cyc = 0;

    logic [7:0] exp_q[$];

    uart_rx #(
        .BAUD_RATE   (115_200),
        .CLOCK_SPEED (50_000_000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Scoreboard side: every strobe is counted and each rx_valid is matched
    // against the oldest expected byte.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (rx_valid === 1'b1) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                check("valid_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("data", 32'(data), 32'(exp_q.pop_front()));
                end
            end
            if (frame_err === 1'b1) ferr_cnt++;
            if (rx_valid === 1'b1 || frame_err === 1'b1) begin
                check("strobe_exclusive", 32'(rx_valid & frame_err), 32'd0);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; returns on a negedge with the line idle high.
    task automatic send_frame(input logic [7:0] b, input int bw, input logic stop_bit);
        rx = 1'b0;
        start_cyc = cyc;
        wait_cycles(bw);
        for (int i = 0; i < 8; i++) begin
            rx = ~b[i];
            wait_cycles(bw);
        end
        rx = stop_bit;
        wait_cycles(bw);
        rx = 1'b1;
    endtask

    initial begin
        int v0;
        int f0;
        logic [7:0] rb;

        rst = 1'b0;
        rx  = 1'b1;
        wait_cycles(5);

        // Reset state
        check("rst_data", 32'(data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        wait_cycles(20);

        // Single byte with latency measurement
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, BW, 1'b1);
        wait_cycles(500);
        check("a5_valid_cnt", 32'(valid_cnt), 32'd1);
        check("a5_ferr_cnt", 32'(ferr_cnt), 32'd0);
        check("a5_data_hold", 32'(data), 32'hA5);
        check("a5_latency_ok",
              32'((last_valid_cyc - start_cyc) >= 4125 && (last_valid_cyc - start_cyc) <= 4127), 32'd1);

        // Back-to-back frames, no idle gap between stop and next start
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h81);
        send_frame(8'h00, BW, 1'b1);
        send_frame(8'hFF, BW, 1'b1);
        send_frame(8'h3C, BW, 1'b1);
        send_frame(8'h81, BW, 1'b1);
        wait_cycles(500);
        check("b2b_valid_cnt", 32'(valid_cnt), 32'd5);
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
        check("b2b_ferr_cnt", 32'(ferr_cnt), 32'd0);

        // Glitch: 100-cycle low pulse is rejected at mid-start
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        wait_cycles(50);
        check("glitch_busy_high", 32'(busy), 32'd1);
        wait_cycles(50);
        rx = 1'b1;
        wait_cycles(200);
        check("glitch_busy_low", 32'(busy), 32'd0);
        check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        wait_cycles(100);

        // Framing error: stop bit low, data keeps the last good byte
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h42, BW, 1'b0);
        wait_cycles(1000);
        check("ferr_count", 32'(ferr_cnt - f0), 32'd1);
        check("ferr_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("ferr_data_kept", 32'(data), 32'h81);
        check("ferr_idle", 32'(busy), 32'd0);

        // Reset during data bit 4; remaining line bits are high so no new
        // start edge appears after release.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rb = 8'h0F;
        rx = 1'b0;
        wait_cycles(BW);
        for (int i = 0; i < 4; i++) begin
            rx = ~rb[i];
            wait_cycles(BW);
        end
        rx = ~rb[4];
        wait_cycles(200);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_data", 32'(data), 32'h00);
        check("async_rst_valid", 32'(rx_valid), 32'd0);
        check("async_rst_ferr", 32'(frame_err), 32'd0);
        wait_cycles(5);
        rst = 1'b1;
        wait_cycles(BW - 205);
        for (int i = 5; i < 8; i++) begin
            rx = ~rb[i];
            wait_cycles(BW);
        end
        rx = 1'b1;
        wait_cycles(BW + 500);
        check("rst_frame_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("rst_frame_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("rst_frame_idle", 32'(busy), 32'd0);

        exp_q.push_back(8'h99);
        send_frame(8'h99, BW, 1'b1);
        wait_cycles(500);
        check("after_rst_valid", 32'(valid_cnt - v0), 32'd1);
        check("after_rst_data", 32'(data), 32'h99);

        // Baud tolerance: bits stretched to 443 cycles
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 443, 1'b1);
        wait_cycles(500);
        check("slow_valid", 32'(valid_cnt - v0), 32'd2);
        check("slow_data", 32'(data), 32'hC3);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_ferr_total", 32'(ferr_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the same UART link driven by uart_tx. Converts one 10-bit line frame into a parallel byte.
- Frame format: 1 start bit (low), 8 payload bits LSB first, 1 stop bit (high).
- Line payload bits are the bitwise complement of the byte. The receiver re-inverts them so a byte sent by uart_tx appears unchanged at data.
- Sits between the board RX pin and the consumer logic. Consumer takes a byte on a single-cycle rx_valid strobe; there is no backpressure.

Parameters:
- BAUD_RATE, 115_200, line bit rate in bits/s.
- CLOCK_SPEED, 50_000_000, clk frequency in Hz.
- BAUD_WIDTH (derived), CLOCK_SPEED / BAUD_RATE = 434, clk cycles per bit.
- HALF_WIDTH (derived), BAUD_WIDTH / 2 = 217, cycles from start-edge detection to mid-start-bit.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, asynchronous to clk; idles high.
- data  output  8  last correctly framed byte, payload already re-inverted.
- rx_valid  output  1  one-cycle strobe: data updated this cycle.
- frame_err  output  1  one-cycle strobe: stop bit sampled low, byte discarded.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst low, async):
  - state = IDLE; counter = 0; bit index = 0; shift register = 0.
  - Synchronizer flops = 1.
  - data = 8'h00; rx_valid = 0; frame_err = 0; busy = 0.
- Reset mid-frame aborts the frame: no strobe, and a fresh falling edge is required after release.
- Input path: 2-flop synchronizer on rx. All logic below uses the synchronized value rx_s, which lags rx by 2 clk.
- States are one-hot: IDLE, START, DATA, STOP.
- IDLE: counter = 0. rx_s = 0 -> START.
- START:
  - Counter increments each cycle.
  - When counter == HALF_WIDTH-1, sample rx_s:
    - rx_s = 0 -> DATA, counter = 0, bit index = 0.
    - rx_s = 1 -> IDLE (glitch reject, no strobe).
- DATA:
  - Counter runs 0..BAUD_WIDTH-1.
  - At counter == BAUD_WIDTH-1: shift ~rx_s into the MSB of an 8-bit shift register (right shift, so LSB-first ends aligned), clear counter, increment bit index.
  - After the 8th sample (bit index 7) -> STOP.
- STOP: at counter == BAUD_WIDTH-1, sample rx_s, then -> IDLE in the same cycle.
  - rx_s = 1: next cycle data = shift register and rx_valid = 1 for exactly 1 cycle.
  - rx_s = 0: next cycle frame_err = 1 for 1 cycle; data keeps its old value.
- Sampling instant: every sample lands at mid-bit, i.e. HALF_WIDTH + k·BAUD_WIDTH cycles after detection (±2 cycles synchronizer skew).
- Back-to-back frames: returning to IDLE at mid-stop lets a start bit immediately following the stop bit be detected with no lost frame.
- Counter width is $clog2(BAUD_WIDTH). The counter never wraps past BAUD_WIDTH-1.
- data holds its value until the next valid frame.
- rx_valid and frame_err are never high in the same cycle.
- Latency: rx_valid rises 2 + HALF_WIDTH + 9·BAUD_WIDTH + 1 cycles after the start-bit falling edge on rx (±1 cycle).
- Illegal state encoding -> IDLE.

Decomposition:
- Package uart_pkg holds:
  - the state typedef (one-hot 4-bit enum IDLE/START/DATA/STOP), shared with uart_tx;
  - DATA_BITS = 8;
  - helper function baud_width(clock_speed, baud_rate).
- Sub-module sync_2ff (generic 2-flop bit synchronizer, async active-low reset, reset value parameterised). Reused on other async inputs.

Test Plan:
- Single byte: drive the line frame for byte 8'hA5 (line payload 8'h5A, LSB first, 434 cycles/bit) -> exactly one rx_valid, data = 8'hA5, frame_err never high.
- Loopback: uart_tx.tx -> uart_rx.rx; send 8'h00, 8'hFF, 8'h3C, 8'h81 back-to-back, each triggered on tx_done -> four rx_valid strobes with matching data, in order.
- Glitch: rx low for 100 cycles, then high -> busy rises then falls after ~217 cycles; no rx_valid, no frame_err.
- Framing error: valid start and data for 8'h42 with stop bit low -> frame_err 1 cycle, no rx_valid, data retains its previous value.
- Reset mid-frame: assert rst during DATA bit 4 of a frame -> all outputs reset immediately (async). The remainder of that frame produces no strobe; the next full frame for 8'h99 gives data = 8'h99.
- Baud tolerance: line bits stretched to 443 cycles (+2%), byte 8'hC3 -> rx_valid with data = 8'hC3.
